// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: UART receive FIFO behind a valid/ready bus with data (pop-on-read) and status/control registers.
// Define SERIAL_RX_FIFO_IRQ_EN to build the level/overrun/timeout interrupt; otherwise irq is tied low.
module serial_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int IRQ_LEVEL  = 8,
  parameter int TIMEOUT    = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovr_q, ovr_d, irq_w;
  logic                  empty, full, rd, ctl_wr, flush, clr, pop, push, ovr_set;
  logic [15:0]           cnt16;
  logic [31:0]           status;
  assign empty   = count_q == '0;
  assign full    = count_q == FULL_CNT;
  assign rd      = valid && wstrb == 4'h0;
  assign ctl_wr  = valid && addr[2] && wstrb[0];
  assign flush   = ctl_wr && wdata[0];
  assign clr     = ctl_wr && wdata[1];
  assign pop     = rd && !addr[2] && !empty;
  // a same-cycle pop frees a slot, so a full FIFO still takes the incoming byte
  assign push    = in_valid && (!full || pop) && !flush;
  assign ovr_set = in_valid && full && !pop;
  assign ready   = valid;
  assign cnt16   = 16'(count_q);
  assign status  = {16'h0, cnt16[7:0], 4'h0, irq_w, ovr_q, full, empty};
  assign rdata   = !valid ? 32'h0 : addr[2] ? status : empty ? 32'hFFFF_FFFF : {24'h0, mem_q[rp_q]};
  assign irq     = irq_w;
  always_comb begin
    wp_d    = push ? wp_q + PTR_ONE : wp_q;
    rp_d    = flush ? wp_q : pop ? rp_q + PTR_ONE : rp_q;
    count_d = flush ? '0 : (push && !pop) ? count_q + CNT_ONE : (pop && !push) ? count_q - CNT_ONE : count_q;
    ovr_d   = ovr_set || (ovr_q && !clr);
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_data;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
    end
  end
`ifdef SERIAL_RX_FIFO_IRQ_EN
  localparam logic [31:0]         TMO = 32'(TIMEOUT);
  localparam logic [DEPTH_LOG2:0] LVL = (DEPTH_LOG2 + 1)'(IRQ_LEVEL);
  logic [31:0] idle_q, idle_d;
  logic        tmo_q, tmo_d, irq_q, irq_d;
  logic        unused;
  assign unused = ^{addr[31:3], addr[1:0], wdata[31:2]};
  // idle counter saturates at TIMEOUT so it never wraps during long stalls
  always_comb begin
    idle_d = (push || pop || flush || empty) ? '0 : idle_q == TMO ? idle_q : idle_q + 32'd1;
    tmo_d  = (pop || flush || empty) ? 1'b0 : (idle_q == TMO) || tmo_q;
    irq_d  = count_q >= LVL || ovr_q || tmo_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tmo_q  <= tmo_d;
      irq_q  <= irq_d;
    end
  end
  assign irq_w = irq_q;
`else
  logic unused;
  assign unused = ^{addr[31:3], addr[1:0], wdata[31:2], 32'(IRQ_LEVEL), 32'(TIMEOUT)};
  assign irq_w  = 1'b0;
`endif
endmodule
